// File: rtl/pll_lock_supervisor.sv
// PLL reset/lock supervisor on the free-running reference clock: pulses the PLL reset, qualifies
// lock, releases the system reset, and retries or latches a fault when lock never arrives.
module pll_lock_supervisor #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRIES   = 8,
  parameter int CNT_W         = 8
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             relock_req,
  output logic             pll_rst,
  output logic             sys_rst,
  output logic             running,
  output logic             fault,
  output logic [3:0]       retry_cnt,
  output logic [CNT_W-1:0] loss_cnt
);

  localparam int T_MAX0 = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int T_MAX  = (T_MAX0 > STABLE_CYCLES) ? T_MAX0 : STABLE_CYCLES;
  localparam int TW     = $clog2(T_MAX + 1);

  // The WAIT_LOCK cycle that first sees lock is the first of the STABLE_CYCLES locked samples,
  // so STABLE itself only needs STABLE_CYCLES-1 more.
  localparam int STB_L = (STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0;

  localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] STB_LAST = TW'(STB_L);
  localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t            state, nxt;
  logic [TW-1:0]     timer;
  logic              locked_meta, locked_s;
  logic              restart, timer_clr;
  logic [3:0]        retry_nxt;
  logic [CNT_W-1:0]  loss_nxt;

  always_ff @(posedge refclk) begin
    if (rst) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= pll_locked;
      locked_s    <= locked_meta;
    end
  end

  always_comb begin
    nxt       = state;
    restart   = 1'b0;
    retry_nxt = retry_cnt;
    loss_nxt  = loss_cnt;
    case (state)
      S_PLL_RST: begin
        if (relock_req)            restart = 1'b1;
        else if (timer == RST_LAST) nxt    = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (relock_req) nxt = S_PLL_RST;
        else if (locked_s) begin
          if (STABLE_CYCLES <= 1) begin
            nxt       = S_RUN;
            retry_nxt = 4'd0;
          end else begin
            nxt = S_STABLE;
          end
        end else if (timer == TMO_LAST) begin
          retry_nxt = retry_cnt + 4'd1;
          nxt       = (retry_nxt == RETRY_MAX) ? S_FAULT : S_PLL_RST;
        end
      end
      S_STABLE: begin
        if (relock_req)            nxt = S_PLL_RST;
        else if (!locked_s)        nxt = S_WAIT_LOCK;
        else if (timer == STB_LAST) begin
          nxt       = S_RUN;
          retry_nxt = 4'd0;
        end
      end
      S_RUN: begin
        // Lock loss is checked first so a coincident relock still records the loss.
        if (!locked_s) begin
          nxt = S_PLL_RST;
          if (loss_cnt != {CNT_W{1'b1}}) loss_nxt = loss_cnt + 1'b1;
        end else if (relock_req) begin
          nxt = S_PLL_RST;
        end
      end
      S_FAULT: nxt = S_FAULT;
      default: nxt = S_PLL_RST;
    endcase
    timer_clr = restart || (nxt != state);
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state     <= S_PLL_RST;
      timer     <= '0;
      pll_rst   <= 1'b1;
      sys_rst   <= 1'b1;
      running   <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= 4'd0;
      loss_cnt  <= '0;
    end else begin
      state     <= nxt;
      retry_cnt <= retry_nxt;
      loss_cnt  <= loss_nxt;
      if (timer_clr)                                                    timer <= '0;
      else if (state == S_PLL_RST || state == S_WAIT_LOCK || state == S_STABLE) timer <= timer + 1'b1;
      pll_rst   <= (nxt == S_PLL_RST) || (nxt == S_FAULT);
      sys_rst   <= (nxt != S_RUN);
      running   <= (nxt == S_RUN);
      fault     <= (nxt == S_FAULT);
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with small parameters; expected timings hand-derived.
module tb_pll_lock_supervisor;
  localparam int RC = 4, LT = 20, SC = 8, MR = 3, CW = 2;

  logic          refclk = 1'b0;
  logic          rst = 1'b1, pll_locked = 1'b0, relock_req = 1'b0;
  logic          pll_rst, sys_rst, running, fault;
  logic [3:0]    retry_cnt;
  logic [CW-1:0] loss_cnt;

  int n_chk = 0, n_fail = 0;

  pll_lock_supervisor #(
    .RST_CYCLES(RC), .LOCK_TIMEOUT(LT), .STABLE_CYCLES(SC), .MAX_RETRIES(MR), .CNT_W(CW)
  ) dut (
    .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .sys_rst(sys_rst), .running(running), .fault(fault),
    .retry_cnt(retry_cnt), .loss_cnt(loss_cnt)
  );

  always #5 refclk = ~refclk;

  task automatic tick();
    @(posedge refclk);
    #1;
  endtask

  // Leaves the bench just after the last reset edge (E0) with rst deasserted.
  task automatic do_reset();
    rst = 1'b1; pll_locked = 1'b0; relock_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic wait_running(input string tag);
    for (int i = 0; i < 80 && !running; i++) tick();
    n_chk++;
    if (!running) begin
      n_fail++;
      $display("FAIL %s: running=%0b, required 1 within 80 cycles", tag, running);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); tick();
    n_chk++;
    if ({pll_rst, sys_rst, running, fault, retry_cnt, loss_cnt} !== 10'b1100_0000_00) begin
      n_fail++;
      $display("FAIL reset_vals: got %b, required %b",
               {pll_rst, sys_rst, running, fault, retry_cnt, loss_cnt}, 10'b1100_0000_00);
    end
  endtask

  task automatic test_lock();
    int cnt, n;
    do_reset();
    cnt = 0;
    while (pll_rst && cnt < 20) begin cnt++; tick(); end
    n_chk++;
    if (cnt !== RC) begin n_fail++; $display("FAIL lock_rst_width: got %0d, required %0d", cnt, RC); end
    tick(); tick();
    pll_locked = 1'b1;
    n = 0;
    while (sys_rst && n < 40) begin tick(); n++; end
    n_chk++;
    if (n !== 2 + SC) begin n_fail++; $display("FAIL lock_sys_rst_delay: got %0d, required %0d", n, 2 + SC); end
    n_chk++;
    if ({running, pll_rst, retry_cnt} !== 6'b10_0000) begin
      n_fail++;
      $display("FAIL lock_run_state: {running,pll_rst,retry}=%b, required 100000", {running, pll_rst, retry_cnt});
    end
  endtask

  task automatic test_timeout();
    logic       e_rst, e_fault;
    logic [3:0] e_retry;
    do_reset();
    for (int k = 0; k < 80; k++) begin
      e_rst   = (k >= 72) || ((k % 24) < 4);
      e_fault = (k >= 72);
      e_retry = (k >= 72) ? 4'd3 : 4'(k / 24);
      n_chk++;
      if ({pll_rst, sys_rst, fault, retry_cnt} !== {e_rst, 1'b1, e_fault, e_retry}) begin
        n_fail++;
        $display("FAIL timeout_seq[%0d]: {pll_rst,sys_rst,fault,retry}=%b, required %b",
                 k, {pll_rst, sys_rst, fault, retry_cnt}, {e_rst, 1'b1, e_fault, e_retry});
      end
      tick();
    end
    relock_req = 1'b1; tick(); relock_req = 1'b0; tick(); tick();
    n_chk++;
    if ({fault, pll_rst, sys_rst, running, retry_cnt} !== 8'b1110_0011) begin
      n_fail++;
      $display("FAIL fault_relock_ignored: got %b, required 11100011", {fault, pll_rst, sys_rst, running, retry_cnt});
    end
    rst = 1'b1; tick(); rst = 1'b0;
    n_chk++;
    if ({fault, pll_rst, retry_cnt} !== 6'b01_0000) begin
      n_fail++;
      $display("FAIL fault_rst_clear: {fault,pll_rst,retry}=%b, required 010000", {fault, pll_rst, retry_cnt});
    end
  endtask

  task automatic test_run_glitch();
    int cnt;
    do_reset(); pll_locked = 1'b1;
    wait_running("glitch_reach_run");
    pll_locked = 1'b0; tick(); pll_locked = 1'b1;
    n_chk++;
    if (sys_rst !== 1'b0) begin n_fail++; $display("FAIL glitch_c1: sys_rst=%b, required 0", sys_rst); end
    tick();
    n_chk++;
    if ({sys_rst, pll_rst} !== 2'b00) begin n_fail++; $display("FAIL glitch_c2: {sys_rst,pll_rst}=%b, required 00", {sys_rst, pll_rst}); end
    tick();
    n_chk++;
    if ({sys_rst, pll_rst, running, loss_cnt} !== 5'b110_01) begin
      n_fail++;
      $display("FAIL glitch_c3: {sys_rst,pll_rst,running,loss}=%b, required 11001", {sys_rst, pll_rst, running, loss_cnt});
    end
    cnt = 0;
    while (pll_rst && cnt < 20) begin cnt++; tick(); end
    n_chk++;
    if (cnt !== RC) begin n_fail++; $display("FAIL glitch_pulse: got %0d, required %0d", cnt, RC); end
    wait_running("glitch_relock");
    n_chk++;
    if ({loss_cnt, retry_cnt} !== 6'b01_0000) begin
      n_fail++;
      $display("FAIL glitch_after: {loss,retry}=%b, required 010000", {loss_cnt, retry_cnt});
    end
  endtask

  // One timeout first so retry_cnt=1 can be seen to survive the STABLE glitch.
  task automatic test_stable_glitch();
    logic       e_sys, e_prst;
    logic [3:0] e_retry;
    do_reset();
    for (int k = 0; k < 24; k++) tick();
    n_chk++;
    if (retry_cnt !== 4'd1) begin n_fail++; $display("FAIL stable_pre_retry: got %0d, required 1", retry_cnt); end
    pll_locked = 1'b1;
    for (int k = 25; k <= 44; k++) begin
      tick();
      if (k == 32) pll_locked = 1'b0;
      if (k == 33) pll_locked = 1'b1;
      e_sys   = (k < 43);
      e_retry = (k < 43) ? 4'd1 : 4'd0;
      e_prst  = (k < 28);
      n_chk++;
      if ({sys_rst, pll_rst, retry_cnt} !== {e_sys, e_prst, e_retry}) begin
        n_fail++;
        $display("FAIL stable_glitch[%0d]: {sys_rst,pll_rst,retry}=%b, required %b",
                 k, {sys_rst, pll_rst, retry_cnt}, {e_sys, e_prst, e_retry});
      end
    end
  endtask

  task automatic test_saturate();
    logic [CW-1:0] e_loss;
    do_reset(); pll_locked = 1'b1;
    wait_running("sat_reach_run");
    for (int i = 1; i <= 4; i++) begin
      pll_locked = 1'b0; tick(); pll_locked = 1'b1; tick(); tick();
      e_loss = (i > 3) ? 2'd3 : CW'(i);
      n_chk++;
      if (loss_cnt !== e_loss) begin n_fail++; $display("FAIL sat_loss[%0d]: got %0d, required %0d", i, loss_cnt, e_loss); end
      wait_running("sat_relock");
    end
  endtask

  // relock_req is timed to reach the FSM on the same cycle as locked_s=0.
  task automatic test_relock();
    int cnt;
    do_reset(); pll_locked = 1'b1;
    wait_running("relock_reach_run");
    pll_locked = 1'b0; tick(); pll_locked = 1'b1; tick();
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    n_chk++;
    if ({pll_rst, loss_cnt} !== 3'b1_01) begin
      n_fail++;
      $display("FAIL relock_coinc: {pll_rst,loss}=%b, required 101", {pll_rst, loss_cnt});
    end
    cnt = 0;
    while (pll_rst && cnt < 20) begin cnt++; tick(); end
    n_chk++;
    if (cnt !== RC) begin n_fail++; $display("FAIL relock_coinc_pulse: got %0d, required %0d", cnt, RC); end
    wait_running("relock_back1");
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    n_chk++;
    if ({pll_rst, running} !== 2'b10) begin
      n_fail++;
      $display("FAIL relock_alone: {pll_rst,running}=%b, required 10", {pll_rst, running});
    end
    cnt = 0;
    while (pll_rst && cnt < 20) begin cnt++; tick(); end
    n_chk++;
    if (cnt !== RC) begin n_fail++; $display("FAIL relock_alone_pulse: got %0d, required %0d", cnt, RC); end
    n_chk++;
    if (loss_cnt !== 2'd1) begin n_fail++; $display("FAIL relock_alone_loss: got %0d, required 1", loss_cnt); end
    wait_running("relock_back2");
  endtask

  task automatic test_relock_edges();
    int cnt;
    do_reset();
    tick(); tick();
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    cnt = 0;
    while (pll_rst && cnt < 20) begin cnt++; tick(); end
    n_chk++;
    if (cnt !== RC) begin n_fail++; $display("FAIL edge_rst_extend: got %0d, required %0d", cnt, RC); end
    for (int i = 0; i < LT - 1; i++) tick();
    relock_req = 1'b1; tick(); relock_req = 1'b0;
    n_chk++;
    if ({pll_rst, retry_cnt} !== 5'b1_0000) begin
      n_fail++;
      $display("FAIL edge_relock_vs_tmo: {pll_rst,retry}=%b, required 10000", {pll_rst, retry_cnt});
    end
    for (int i = 0; i < RC + LT; i++) tick();
    n_chk++;
    if ({pll_rst, retry_cnt} !== 5'b1_0001) begin
      n_fail++;
      $display("FAIL edge_tmo_after: {pll_rst,retry}=%b, required 10001", {pll_rst, retry_cnt});
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_timeout();
    test_run_glitch();
    test_stable_glitch();
    test_saturate();
    test_relock();
    test_relock_edges();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
